// File: rtl/ccg_parity_fanout_pipe.sv
// ccg_parity_fanout_pipe
// Programmable gated-parity evaluator with run-time loaded tap/gate masks and
// a per-output group select. Two-stage valid/ready pipeline: S1 holds the
// per-group results, S2 holds the fanned-out output vector.
module ccg_parity_fanout_pipe #(
    parameter int NUM_IN  = 26,
    parameter int NUM_OUT = 30,
    parameter int NUM_GRP = 2,
    parameter int GW      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUM_IN-1:0]  x,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] f,
    input  logic               cfg_we,
    input  logic [7:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic               cfg_err,
    output logic [15:0]        out_cnt
);

    localparam int MAP_BASE = 4 * NUM_GRP;

    // Gated parity of one group: gate requires every one_mask input high and
    // every zero_mask input low; result is the tapped parity xor inv, gated.
    function automatic logic grp_eval(
        input logic [NUM_IN-1:0] xv,
        input logic [NUM_IN-1:0] par,
        input logic [NUM_IN-1:0] one,
        input logic [NUM_IN-1:0] zero,
        input logic              inv_bit
    );
        logic gate;
        gate = (&(xv | ~one)) & (&(~xv | ~zero));
        return gate & ((^(xv & par)) ^ inv_bit);
    endfunction

    // configuration state
    logic [NUM_IN-1:0]  par_mask_r  [NUM_GRP];
    logic [NUM_IN-1:0]  one_mask_r  [NUM_GRP];
    logic [NUM_IN-1:0]  zero_mask_r [NUM_GRP];
    logic [NUM_GRP-1:0] inv_r;
    logic [GW-1:0]      sel_r       [NUM_OUT];

    // pipeline state
    logic               s1_v_r;
    logic [NUM_GRP-1:0] s1_res_r;
    logic               s2_v_r;
    logic [NUM_OUT-1:0] f_r;
    logic               cfg_err_r;
    logic [15:0]        out_cnt_r;

    // combinational helpers
    logic               addr_grp_s;
    logic               addr_map_s;
    logic [5:0]         grp_idx_s;
    logic [7:0]         map_idx_s;
    logic [NUM_GRP-1:0] grp_res_s;
    logic [NUM_OUT-1:0] f_next_s;
    logic               s2_free_s;
    logic               s2_load_s;
    logic               s1_load_s;
    logic               in_ready_s;
    logic               unused_s;

    // Upper write-data bits beyond a field are intentionally ignored.
    assign unused_s = ^cfg_wdata;

    // Decode the config address into a group field or an output-map entry.
    always_comb begin
        addr_grp_s = (cfg_addr < 8'(MAP_BASE));
        addr_map_s = (cfg_addr >= 8'(MAP_BASE)) && (cfg_addr < 8'(MAP_BASE + NUM_OUT));
        grp_idx_s  = cfg_addr[7:2];
        map_idx_s  = cfg_addr - 8'(MAP_BASE);
    end

    // Config register file; a write becomes visible to the next accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NUM_GRP; g++) begin
                par_mask_r[g]  <= {NUM_IN{1'b0}};
                one_mask_r[g]  <= {NUM_IN{1'b0}};
                zero_mask_r[g] <= {NUM_IN{1'b0}};
            end
            inv_r <= {NUM_GRP{1'b0}};
            for (int o = 0; o < NUM_OUT; o++) begin
                sel_r[o] <= GW'(o % NUM_GRP);
            end
        end else if (cfg_we) begin
            if (addr_grp_s) begin
                for (int g = 0; g < NUM_GRP; g++) begin
                    if (grp_idx_s == 6'(g)) begin
                        case (cfg_addr[1:0])
                            2'd0:    par_mask_r[g]  <= cfg_wdata[NUM_IN-1:0];
                            2'd1:    one_mask_r[g]  <= cfg_wdata[NUM_IN-1:0];
                            2'd2:    zero_mask_r[g] <= cfg_wdata[NUM_IN-1:0];
                            2'd3:    inv_r[g]       <= cfg_wdata[0];
                            default: inv_r[g]       <= inv_r[g];
                        endcase
                    end
                end
            end else if (addr_map_s) begin
                for (int o = 0; o < NUM_OUT; o++) begin
                    if (map_idx_s == 8'(o)) begin
                        sel_r[o] <= cfg_wdata[GW-1:0];
                    end
                end
            end
        end
    end

    // Evaluate every group on the incoming vector with the current config.
    always_comb begin
        grp_res_s = {NUM_GRP{1'b0}};
        for (int g = 0; g < NUM_GRP; g++) begin
            grp_res_s[g] = grp_eval(x, par_mask_r[g], one_mask_r[g], zero_mask_r[g], inv_r[g]);
        end
    end

    // Fan the S1 group results out to outputs using the live select map.
    always_comb begin
        f_next_s = {NUM_OUT{1'b0}};
        for (int o = 0; o < NUM_OUT; o++) begin
            f_next_s[o] = s1_res_r[sel_r[o]];
        end
    end

    // Stage handshakes: a stage loads when empty or when it drains this cycle.
    always_comb begin
        s2_free_s  = ~s2_v_r | out_ready;
        s2_load_s  = s1_v_r & s2_free_s;
        in_ready_s = ~s1_v_r | s2_free_s;
        s1_load_s  = in_valid & in_ready_s;
    end

    // S1: capture group results for an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r   <= 1'b0;
            s1_res_r <= {NUM_GRP{1'b0}};
        end else if (s1_load_s) begin
            s1_v_r   <= 1'b1;
            s1_res_r <= grp_res_s;
        end else if (s2_load_s) begin
            s1_v_r   <= 1'b0;
        end
    end

    // S2: capture the fanned-out vector; hold it while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_r <= 1'b0;
            f_r    <= {NUM_OUT{1'b0}};
        end else if (s2_load_s) begin
            s2_v_r <= 1'b1;
            f_r    <= f_next_s;
        end else if (out_ready) begin
            s2_v_r <= 1'b0;
        end
    end

    // Flag writes that hit no mapped register, one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg_we & ~(addr_grp_s | addr_map_s);
        end
    end

    // Count completed output handshakes, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt_r <= 16'd0;
        end else if (s2_v_r & out_ready) begin
            out_cnt_r <= out_cnt_r + 16'd1;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_v_r;
    assign f         = f_r;
    assign cfg_err   = cfg_err_r;
    assign out_cnt   = out_cnt_r;

endmodule

// File: tb/tb_ccg_parity_fanout_pipe.sv
// Testbench for ccg_parity_fanout_pipe: table vectors and hand sequences
// driven through a scoreboard queue checked at every output handshake.
module tb_ccg_parity_fanout_pipe;

    localparam int NI = 26;
    localparam int NO = 30;
    localparam int NG = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [NI-1:0] x = '0;
    logic          cfg_we = 1'b0;
    logic [7:0]    cfg_addr = 8'd0;
    logic [31:0]   cfg_wdata = 32'd0;
    logic          in_ready;
    logic          out_valid;
    logic [NO-1:0] f;
    logic          cfg_err;
    logic [15:0]   out_cnt;

    int            checks = 0;
    int            errors = 0;
    logic [NO-1:0] exp_q [$];
    logic [NO-1:0] mon_e;
    logic [15:0]   hs_cnt = 16'd0;
    logic [15:0]   hs0;

    // reference config
    logic [NI-1:0] m_par [NG];
    logic [NI-1:0] m_one [NG];
    logic [NI-1:0] m_zero [NG];
    logic          m_inv [NG];
    int            m_sel [NO];

    typedef struct {
        logic [NI-1:0] xv;
        logic [NO-1:0] fv;
    } vec_t;
    vec_t g0_tab [4];
    vec_t mx_tab [2];
    logic [NI-1:0] bp_x [5];
    logic [NO-1:0] bp_exp0;
    int            idx;

    ccg_parity_fanout_pipe #(.NUM_IN(NI), .NUM_OUT(NO), .NUM_GRP(NG)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .out_valid(out_valid), .out_ready(out_ready), .f(f),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_err(cfg_err), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    // Output monitor: every handshake must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got f=%h with no sample pending", f);
            end else begin
                mon_e = exp_q.pop_front();
                if (f !== mon_e) begin
                    errors++;
                    $display("FAIL scoreboard_f: got %h expected %h", f, mon_e);
                end
            end
            hs_cnt = hs_cnt + 16'd1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < NG; g++) begin
            m_par[g] = '0; m_one[g] = '0; m_zero[g] = '0; m_inv[g] = 1'b0;
        end
        for (int o = 0; o < NO; o++) m_sel[o] = o % NG;
    endtask

    function automatic logic [NO-1:0] model_f(input logic [NI-1:0] xv);
        logic [NG-1:0] gr;
        logic [NO-1:0] r;
        logic          gate;
        for (int g = 0; g < NG; g++) begin
            gate  = (&(xv | ~m_one[g])) & (&(~xv | ~m_zero[g]));
            gr[g] = gate & ((^(xv & m_par[g])) ^ m_inv[g]);
        end
        for (int o = 0; o < NO; o++) r[o] = gr[m_sel[o]];
        return r;
    endfunction

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (a < 8'(4 * NG)) begin
            case (a % 4)
                0: m_par[a / 4]  = d[NI-1:0];
                1: m_one[a / 4]  = d[NI-1:0];
                2: m_zero[a / 4] = d[NI-1:0];
                default: m_inv[a / 4] = d[0];
            endcase
        end else if (a < 8'(4 * NG + NO)) begin
            m_sel[a - 8'(4 * NG)] = int'(d[0]);
        end
    endtask

    // Present one sample and push its expectation in the cycle it is accepted.
    task automatic send(input logic [NI-1:0] xv, input logic [NO-1:0] ev);
        int n;
        n = 0;
        in_valid = 1'b1; x = xv;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end else begin
            exp_q.push_back(ev);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        g0_tab[0] = '{26'h0000000, 30'h3FFFFFFF};
        g0_tab[1] = '{26'h0000080, 30'h00000000};
        g0_tab[2] = '{26'h0000020, 30'h00000000};
        g0_tab[3] = '{26'h0004080, 30'h3FFFFFFF};
        mx_tab[0] = '{26'h0000200, 30'h3FFFFFFD};
        mx_tab[1] = '{26'h0004200, 30'h00000002};
        bp_x[0] = 26'h0000000; bp_x[1] = 26'h0000080; bp_x[2] = 26'h0004080;
        bp_x[3] = 26'h0000020; bp_x[4] = 26'h0000001;
        model_reset();

        // reset defaults
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_f", f, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_out_cnt", out_cnt, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        send(26'h3FFFFFF, 30'h0);
        in_valid = 1'b0;
        check("lat_not_early", out_valid, 0);
        @(posedge clk); #1;
        check("lat_valid_n2", out_valid, 1);
        check("lat_f_n2", f, 0);
        drain();
        check("rst_cnt_one", out_cnt, 1);

        // group 0 configuration, all outputs mapped to group 0
        cfg_write(8'd0, 32'h00804080);
        cfg_write(8'd2, 32'h00000420);
        cfg_write(8'd3, 32'h00000001);
        check("cfg_err_quiet", cfg_err, 0);
        for (int o = 0; o < NO; o++) cfg_write(8'(8 + o), 32'h0);
        hs0 = hs_cnt;
        for (int i = 0; i < 4; i++) send(g0_tab[i].xv, g0_tab[i].fv);
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("g0_back_to_back", hs_cnt - hs0, 4);
        drain();

        // backpressure: stall 5 cycles with a continuous source
        hs0 = hs_cnt;
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1; x = bp_x[0];
        bp_exp0 = model_f(bp_x[0]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, (k < 2) ? 1 : 0);
            if (in_ready) begin
                exp_q.push_back(model_f(bp_x[idx]));
                idx++;
            end
            if (k >= 2) begin
                check("bp_f_held", f, bp_exp0);
                check("bp_valid_held", out_valid, 1);
            end
            @(posedge clk); #1;
            x = bp_x[idx];
        end
        check("bp_accepts", idx, 2);
        out_ready = 1'b1;
        for (int i = 2; i < 5; i++) send(bp_x[i], model_f(bp_x[i]));
        in_valid = 1'b0;
        drain();
        check("bp_hs_count", hs_cnt - hs0, 5);
        check("bp_out_cnt", out_cnt, hs_cnt);

        // mixed map: output 1 from group 1
        cfg_write(8'd4, 32'h00004000);
        cfg_write(8'd5, 32'h00000200);
        cfg_write(8'd9, 32'h00000001);
        for (int i = 0; i < 2; i++) send(mx_tab[i].xv, mx_tab[i].fv);
        in_valid = 1'b0;
        drain();

        // config hazard: inv write in the same cycle as an acceptance
        cfg_we = 1'b1; cfg_addr = 8'd3; cfg_wdata = 32'h0;
        in_valid = 1'b1; x = 26'h0;
        @(negedge clk);
        check("hz_in_ready", in_ready, 1);
        exp_q.push_back(model_f(26'h0));
        @(posedge clk); #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        m_inv[0] = 1'b0;
        send(26'h0, model_f(26'h0));
        in_valid = 1'b0;
        drain();

        // unmapped write
        cfg_write(8'hFF, 32'hFFFFFFFF);
        check("err_pulse", cfg_err, 1);
        @(posedge clk); #1;
        check("err_single", cfg_err, 0);
        send(26'h0, model_f(26'h0));
        send(26'h0000080, model_f(26'h0000080));
        send(26'h0004200, model_f(26'h0004200));
        in_valid = 1'b0;
        drain();

        // counter wrap from a fresh reset
        rst_n = 1'b0;
        exp_q.delete(); model_reset(); hs_cnt = 16'd0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) send(NI'($urandom), 30'h0);
        in_valid = 1'b0;
        drain();
        check("wrap_ffff", out_cnt, 16'hFFFF);
        send(26'h1234567, 30'h0);
        in_valid = 1'b0;
        drain();
        check("wrap_zero", out_cnt, 16'h0000);

        // reset with both stages full
        out_ready = 1'b0;
        send(26'h0000001, 30'h0);
        send(26'h0000002, 30'h0);
        in_valid = 1'b0;
        check("mr_full_valid", out_valid, 1);
        check("mr_full_stall", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mr_valid_drop", out_valid, 0);
        check("mr_f_clear", f, 0);
        exp_q.delete(); model_reset(); hs_cnt = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("mr_no_stale", out_valid, 0);
        end
        check("mr_cnt_clear", out_cnt, 0);
        send(26'h3FFFFFF, model_f(26'h3FFFFFF));
        in_valid = 1'b0;
        drain();
        check("mr_cnt_after", out_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
